// File: rtl/irq_pkg.sv
// Shared interrupt-line width and vector type, common to the source bank,
// daisy chain and CSR blocks.
package irq_pkg;
    localparam int IRQ_N = 16;
    typedef logic [IRQ_N-1:0] irq_vec_t;
endpackage

// File: rtl/irq_source_bank_if.sv
// Signal bundle between the peripheral source bank and its driver:
// raw lines, mode/mask controls, chain handshake and status readback.
interface irq_source_bank_if
    import irq_pkg::*;
#(
    parameter int N = IRQ_N
);
    logic [N-1:0] irq_src_i;
    logic [N-1:0] edge_mode_i;
    logic [N-1:0] mie_i;
    logic         irq_ack_i;
    logic [N-1:0] irq_cause_i;
    logic [N-1:0] irq_ret_i;
    logic [N-1:0] sw_clear_i;
    logic [N-1:0] masked_irq_o;
    logic [N-1:0] pending_o;
    logic [N-1:0] in_service_o;
    logic [N-1:0] overflow_o;

    modport master (
        output irq_src_i, edge_mode_i, mie_i, irq_ack_i, irq_cause_i,
               irq_ret_i, sw_clear_i,
        input  masked_irq_o, pending_o, in_service_o, overflow_o
    );

    modport slave (
        input  irq_src_i, edge_mode_i, mie_i, irq_ack_i, irq_cause_i,
               irq_ret_i, sw_clear_i,
        output masked_irq_o, pending_o, in_service_o, overflow_o
    );
endinterface

// File: rtl/irq_sync.sv
// Multi-bit flop synchronizer for asynchronous request lines; each bit is
// independent, so no cross-bit coherence is implied.
module irq_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) chain[s] <= '0;
        end else begin
            chain[0] <= d;
            for (int s = 1; s < STAGES; s++) chain[s] <= chain[s-1];
        end
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/irq_source_bank.sv
// Peripheral side of the interrupt handshake: captures raw lines into pending
// bits, tracks in-service/overflow, and feeds masked requests to the chain.
module irq_source_bank
    import irq_pkg::*;
#(
    parameter int N           = IRQ_N,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    irq_source_bank_if.slave   bus
);
    logic [N-1:0] sync, prev, mode_q;
    logic [N-1:0] pending, in_service, overflow;
    logic [N-1:0] rise, mode_chg, retire, edge_pend;
    logic [N-1:0] pending_nxt, overflow_nxt, in_service_nxt;

    irq_sync #(.WIDTH(N), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .d     (bus.irq_src_i),
        .q     (sync)
    );

    // A line still high at reset release shows up as one edge, since prev starts at 0.
    always_comb begin
        rise           = sync & ~prev;
        mode_chg       = bus.edge_mode_i ^ mode_q;
        retire         = bus.irq_ret_i | bus.sw_clear_i;
        edge_pend      = rise | (pending & ~retire);
        pending_nxt    = ~mode_chg & ((bus.edge_mode_i & edge_pend) |
                                      (~bus.edge_mode_i & sync));
        overflow_nxt   = ~mode_chg & bus.edge_mode_i &
                         ((rise & pending & ~retire) | (overflow & ~bus.sw_clear_i));
        in_service_nxt = ({N{bus.irq_ack_i}} & bus.irq_cause_i) |
                         (in_service & ~bus.irq_ret_i);
    end

    // prev always tracks sync, so a mode switch never manufactures an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev       <= '0;
            mode_q     <= '0;
            pending    <= '0;
            overflow   <= '0;
            in_service <= '0;
        end else begin
            prev       <= sync;
            mode_q     <= bus.edge_mode_i;
            pending    <= pending_nxt;
            overflow   <= overflow_nxt;
            in_service <= in_service_nxt;
        end
    end

    assign bus.masked_irq_o = pending & bus.mie_i & ~in_service;
    assign bus.pending_o    = pending;
    assign bus.in_service_o = in_service;
    assign bus.overflow_o   = overflow;
endmodule

// File: tb/tb_irq_source_bank.sv
// Bench for irq_source_bank: cycle vector table through a scoreboard queue,
// plus hand sequences for same-cycle mask, async reset and reset-release edge.
module tb_irq_source_bank;
    import irq_pkg::*;

    typedef struct {
        logic [15:0] src, edg, mie, cause, ret, clr;
        logic        ack;
        logic [15:0] e_mask, e_pend, e_insvc, e_ovf;
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] m, p, s, o;
    } exp_t;

    localparam int NV = 39;
    localparam logic [15:0] E = 16'hFFFF;
    localparam logic [15:0] M = 16'hFFFF;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    vec_t tbl [NV];
    exp_t sbq [$];

    irq_source_bank_if #(.N(16)) bus ();

    irq_source_bank #(.N(16), .SYNC_STAGES(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t v(logic [15:0] src, logic [15:0] edg, logic [15:0] mie,
                               logic ack, logic [15:0] cause, logic [15:0] ret,
                               logic [15:0] clr, logic [15:0] m, logic [15:0] p,
                               logic [15:0] s, logic [15:0] o);
        vec_t r;
        r.src = src; r.edg = edg; r.mie = mie; r.ack = ack; r.cause = cause;
        r.ret = ret; r.clr = clr; r.e_mask = m; r.e_pend = p; r.e_insvc = s;
        r.e_ovf = o;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t r);
        bus.irq_src_i   = r.src;
        bus.edge_mode_i = r.edg;
        bus.mie_i       = r.mie;
        bus.irq_ack_i   = r.ack;
        bus.irq_cause_i = r.cause;
        bus.irq_ret_i   = r.ret;
        bus.sw_clear_i  = r.clr;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] m, input logic [15:0] p,
                           input logic [15:0] s, input logic [15:0] o);
        chk({tag, ".masked"},     bus.masked_irq_o, m);
        chk({tag, ".pending"},    bus.pending_o,    p);
        chk({tag, ".in_service"}, bus.in_service_o, s);
        chk({tag, ".overflow"},   bus.overflow_o,   o);
    endtask

    initial begin
        exp_t e;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        apply(v(16'h0, E, M, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0));

        // columns: src edge mie ack cause ret clr | masked pending in_service overflow
        tbl[0]  = v(16'h0008, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[1]  = v(16'h0008, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[2]  = v(16'h0000, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0008, 16'h0008, 16'h0000, 16'h0000);
        tbl[3]  = v(16'h0000, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0008, 16'h0008, 16'h0000, 16'h0000);
        tbl[4]  = v(16'h0000, E, M, 0, 16'h0, 16'h0008, 16'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[5]  = v(16'h0000, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[6]  = v(16'h0008, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[7]  = v(16'h0008, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[8]  = v(16'h0000, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0008, 16'h0008, 16'h0000, 16'h0000);
        tbl[9]  = v(16'h0000, E, M, 1, 16'h0008, 16'h0, 16'h0, 16'h0000, 16'h0008, 16'h0008, 16'h0000);
        tbl[10] = v(16'h0008, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0000, 16'h0008, 16'h0008, 16'h0000);
        tbl[11] = v(16'h0000, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0000, 16'h0008, 16'h0008, 16'h0000);
        tbl[12] = v(16'h0000, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0000, 16'h0008, 16'h0008, 16'h0008);
        tbl[13] = v(16'h0000, E, M, 0, 16'h0, 16'h0008, 16'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0008);
        tbl[14] = v(16'h0000, E, M, 0, 16'h0, 16'h0, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[15] = v(16'h0000, E, M, 0, 16'hFFFF, 16'h0, 16'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[16] = v(16'h0020, E, 16'hFFDF, 0, 16'h0, 16'h0, 16'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[17] = v(16'h0000, E, 16'hFFDF, 0, 16'h0, 16'h0, 16'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[18] = v(16'h0000, E, 16'hFFDF, 0, 16'h0, 16'h0, 16'h0, 16'h0000, 16'h0020, 16'h0000, 16'h0000);
        tbl[19] = v(16'h0000, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0020, 16'h0020, 16'h0000, 16'h0000);
        tbl[20] = v(16'h0000, E, M, 0, 16'h0, 16'h0, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[21] = v(16'h0004, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[22] = v(16'h0000, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[23] = v(16'h0000, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0004, 16'h0004, 16'h0000, 16'h0000);
        tbl[24] = v(16'h0004, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0004, 16'h0004, 16'h0000, 16'h0000);
        tbl[25] = v(16'h0000, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0004, 16'h0004, 16'h0000, 16'h0000);
        tbl[26] = v(16'h0000, E, M, 0, 16'h0, 16'h0004, 16'h0, 16'h0004, 16'h0004, 16'h0000, 16'h0000);
        tbl[27] = v(16'h0000, 16'hFFFB, M, 0, 16'h0, 16'h0, 16'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[28] = v(16'h0000, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[29] = v(16'h0000, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[30] = v(16'h0001, 16'hFFFE, M, 0, 16'h0, 16'h0, 16'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[31] = v(16'h0001, 16'hFFFE, M, 0, 16'h0, 16'h0, 16'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[32] = v(16'h0001, 16'hFFFE, M, 0, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h0001, 16'h0000, 16'h0000);
        tbl[33] = v(16'h0001, 16'hFFFE, M, 1, 16'h0001, 16'h0, 16'h0, 16'h0000, 16'h0001, 16'h0001, 16'h0000);
        tbl[34] = v(16'h0001, 16'hFFFE, M, 0, 16'h0, 16'h0001, 16'h0, 16'h0001, 16'h0001, 16'h0000, 16'h0000);
        tbl[35] = v(16'h0000, 16'hFFFE, M, 0, 16'h0, 16'h0, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000);
        tbl[36] = v(16'h0000, 16'hFFFE, M, 0, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h0001, 16'h0000, 16'h0000);
        tbl[37] = v(16'h0000, 16'hFFFE, M, 0, 16'h0, 16'h0, 16'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[38] = v(16'h0000, E, M, 0, 16'h0, 16'h0, 16'h0,  16'h0000, 16'h0000, 16'h0000, 16'h0000);

        #2;
        chk_all("reset", 16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i]);
            sbq.push_back('{i, tbl[i].e_mask, tbl[i].e_pend, tbl[i].e_insvc, tbl[i].e_ovf});
            step();
            e = sbq.pop_front();
            chk_all($sformatf("v%0d", e.idx), e.m, e.p, e.s, e.o);
        end

        // Mask change must reach masked_irq_o without a clock edge.
        apply(v(16'h0020, E, 16'hFFDF, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0));
        step();
        bus.irq_src_i = 16'h0;
        step();
        step();
        chk("mask.pending", bus.pending_o, 16'h0020);
        chk("mask.masked_off", bus.masked_irq_o, 16'h0000);
        #2;
        bus.mie_i = 16'hFFFF;
        #1;
        chk("mask.masked_same_cycle", bus.masked_irq_o, 16'h0020);
        bus.sw_clear_i = 16'h0020;
        step();
        bus.sw_clear_i = 16'h0;
        chk("mask.sw_clear", bus.pending_o, 16'h0000);

        // Line 7 in service, then an asynchronous reset mid-cycle.
        bus.irq_src_i = 16'h0080;
        step();
        bus.irq_src_i = 16'h0;
        step();
        step();
        bus.irq_ack_i   = 1'b1;
        bus.irq_cause_i = 16'h0080;
        step();
        bus.irq_ack_i   = 1'b0;
        bus.irq_cause_i = 16'h0;
        chk("rst.pre_in_service", bus.in_service_o, 16'h0080);
        bus.irq_src_i = 16'h0080;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("rst.async", 16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("rst.release_2clk", bus.masked_irq_o, 16'h0000);
        step();
        chk("rst.release_3clk", bus.masked_irq_o, 16'h0080);
        chk("rst.release_pending", bus.pending_o, 16'h0080);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
